// File: rtl/fir_pkg.sv
// Shared FIR definitions: sample format and pointer sizing used by the
// accelerator delay line and the result buffer.
package fir_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int Q_FORMAT   = 8;

    typedef logic signed [DATA_WIDTH-1:0] fir_sample_t;

    // Extra MSB lets wrapping pointers tell full apart from empty.
    function automatic int fir_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_result_mem.sv
// Result storage array: one synchronous write port, one asynchronous read
// port, no reset on the contents.
module fir_result_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                          clk_i,
    input  logic                          wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]      wr_addr_i,
    input  logic signed [DATA_WIDTH-1:0]  wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]      rd_addr_i,
    output logic signed [DATA_WIDTH-1:0]  rd_data_o
);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fir_result_buffer.sv
// Show-ahead result FIFO between the FIR accelerator and a stallable consumer,
// with occupancy flags, sticky overflow and a saturating drop counter.
module fir_result_buffer #(
    parameter int DATA_WIDTH      = fir_pkg::DATA_WIDTH,
    parameter int DEPTH           = 8,
    parameter int ALMOST_FULL_LVL = DEPTH - 2,
    parameter int DROP_CNT_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic                             flush,
    input  logic                             inValid,
    input  logic signed [DATA_WIDTH-1:0]     inData,
    output logic                             outValid,
    input  logic                             outReady,
    output logic signed [DATA_WIDTH-1:0]     outData,
    output logic [$clog2(DEPTH):0]           level,
    output logic                             empty,
    output logic                             full,
    output logic                             almostFull,
    output logic                             overflow,
    output logic [DROP_CNT_WIDTH-1:0]        dropCount
);

    import fir_pkg::*;

    localparam int PW = fir_ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LVL    = PW'(ALMOST_FULL_LVL);

    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic                          overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0]     drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]                 level_w;
    logic                          empty_w, full_w;
    logic                          push_ok, pop_ok, drop_w;
    logic signed [DATA_WIDTH-1:0]  head_w;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_CNT_WIDTH'(1);
    endfunction

    assign level_w = wr_ptr_q - rd_ptr_q;
    assign empty_w = (level_w == '0);
    assign full_w  = (level_w == DEPTH_LVL);

    // A pop frees the slot this same edge, so push is legal when full.
    assign pop_ok  = !empty_w && outReady;
    assign push_ok = inValid && (!full_w || pop_ok);
    assign drop_w  = inValid && full_w && !pop_ok;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (drop_w) begin
                overflow_d = 1'b1;
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fir_result_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i     (clk),
        .wr_en_i   (push_ok && !flush),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (inData),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (head_w)
    );

    // Stale array contents never leak out while the buffer is empty.
    assign outValid   = !empty_w;
    assign outData    = empty_w ? '0 : head_w;
    assign level      = level_w;
    assign empty      = empty_w;
    assign full       = full_w;
    assign almostFull = (level_w >= AF_LVL);
    assign overflow   = overflow_q;
    assign dropCount  = drop_cnt_q;

endmodule

// File: tb/tb_fir_result_buffer.sv
// Scenario bench for fir_result_buffer with a queue scoreboard of expected words.
module tb_fir_result_buffer;

    logic               clk = 1'b0;
    logic               rstN;
    logic               flush;
    logic               inValid;
    logic signed [15:0] inData;
    logic               outValid;
    logic               outReady;
    logic signed [15:0] outData;
    logic [3:0]         level;
    logic               empty, full, almostFull, overflow;
    logic [7:0]         dropCount;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    always #5 clk = ~clk;

    fir_result_buffer #(
        .DATA_WIDTH      (16),
        .DEPTH           (8),
        .ALMOST_FULL_LVL (6),
        .DROP_CNT_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .flush      (flush),
        .inValid    (inValid),
        .inData     (inData),
        .outValid   (outValid),
        .outReady   (outReady),
        .outData    (outData),
        .level      (level),
        .empty      (empty),
        .full       (full),
        .almostFull (almostFull),
        .overflow   (overflow),
        .dropCount  (dropCount)
    );

    // Drive one cycle; the model applies the same edge to the scoreboard.
    task automatic clk_step(input logic v, input logic [15:0] d, input logic rdy, input logic fl);
        inValid  = v;
        inData   = d;
        outReady = rdy;
        flush    = fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (outValid && rdy) got_q.push_back(outData);
            if (sb.size() != 0 && rdy) exp_q.push_back(sb.pop_front());
            if (v && sb.size() < 8) sb.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        repeat (3) clk_step(1'b0, 16'h0, 1'b0, 1'b0);
        total++; if (outValid !== 1'b0)   begin bad++; $display("FAIL reset_outValid got=%b want=0", outValid); end
        total++; if (outData !== 16'h0)   begin bad++; $display("FAIL reset_outData got=%h want=0000", outData); end
        total++; if (level !== 4'd0)      begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (empty !== 1'b1)      begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0)       begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (almostFull !== 1'b0) begin bad++; $display("FAIL reset_almostFull got=%b want=0", almostFull); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (dropCount !== 8'd0)  begin bad++; $display("FAIL reset_dropCount got=%0d want=0", dropCount); end
    endtask

    task automatic test_single();
        clk_step(1'b1, 16'h0199, 1'b1, 1'b0);
        total++; if (outValid !== 1'b1)   begin bad++; $display("FAIL single_valid got=%b want=1", outValid); end
        total++; if (outData !== 16'h0199) begin bad++; $display("FAIL single_data got=%h want=0199", outData); end
        clk_step(1'b0, 16'h0, 1'b1, 1'b0);
        total++; if (outValid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b/%b want=0/1", outValid, empty); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            logic [15:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL single_word got=%h want=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            clk_step(1'b1, 16'(i << 8), 1'b0, 1'b0);
            total++; if (level !== 4'(i)) begin bad++; $display("FAIL fill_level got=%0d want=%0d", level, i); end
            total++; if (almostFull !== (i >= 6)) begin bad++; $display("FAIL fill_almostFull lvl=%0d got=%b want=%b", i, almostFull, (i >= 6)); end
            total++; if (outData !== 16'h0100) begin bad++; $display("FAIL fill_head got=%h want=0100", outData); end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", full); end
    endtask

    task automatic test_overflow();
        repeat (3) clk_step(1'b1, 16'h0900, 1'b0, 1'b0);
        total++; if (dropCount !== 8'd3) begin bad++; $display("FAIL ovf_dropCount got=%0d want=3", dropCount); end
        total++; if (overflow !== 1'b1)  begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        total++; if (level !== 4'd8)     begin bad++; $display("FAIL ovf_level got=%0d want=8", level); end
        repeat (8) clk_step(1'b0, 16'h0, 1'b1, 1'b0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_drained got=%b want=1", empty); end
        total++; if (got_q.size() !== 8) begin bad++; $display("FAIL ovf_count got=%0d want=8", got_q.size()); end
        for (int i = 1; i <= 8 && got_q.size() != 0 && exp_q.size() != 0; i++) begin
            logic [15:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e || g !== 16'(i << 8)) begin bad++; $display("FAIL ovf_word got=%h want=%h", g, 16'(i << 8)); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_push_pop();
        logic [15:0] last;
        for (int i = 1; i <= 8; i++) clk_step(1'b1, 16'(i << 8), 1'b0, 1'b0);
        clk_step(1'b1, 16'hFF00, 1'b1, 1'b0);
        total++; if (level !== 4'd8)     begin bad++; $display("FAIL fpp_level got=%0d want=8", level); end
        total++; if (dropCount !== 8'd3) begin bad++; $display("FAIL fpp_nodrop got=%0d want=3", dropCount); end
        total++; if (outData !== 16'h0200) begin bad++; $display("FAIL fpp_head got=%h want=0200", outData); end
        repeat (8) clk_step(1'b0, 16'h0, 1'b1, 1'b0);
        last = (got_q.size() != 0) ? got_q[got_q.size()-1] : 16'hxxxx;
        total++; if (last !== 16'hFF00) begin bad++; $display("FAIL fpp_last got=%h want=ff00", last); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL fpp_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            logic [15:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL fpp_word got=%h want=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_flush();
        clk_step(1'b0, 16'h0, 1'b0, 1'b1);
        total++; if (dropCount !== 8'd0 || overflow !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0d/%b want=0/0", dropCount, overflow); end
        for (int i = 1; i <= 10; i++) clk_step(1'b1, 16'(i * 16'h0011), 1'b0, 1'b0);
        repeat (3) clk_step(1'b0, 16'h0, 1'b1, 1'b0);
        total++; if (level !== 4'd5 || dropCount !== 8'd2) begin bad++; $display("FAIL flush_setup got=%0d/%0d want=5/2", level, dropCount); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            logic [15:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL flush_word got=%h want=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
        clk_step(1'b1, 16'hAAAA, 1'b0, 1'b1);
        total++; if (level !== 4'd0)     begin bad++; $display("FAIL flush_level got=%0d want=0", level); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL flush_overflow got=%b want=0", overflow); end
        total++; if (dropCount !== 8'd0) begin bad++; $display("FAIL flush_dropCount got=%0d want=0", dropCount); end
        clk_step(1'b0, 16'h0, 1'b0, 1'b0);
        total++; if (outValid !== 1'b0 || outData !== 16'h0) begin bad++; $display("FAIL flush_discard got=%b/%h want=0/0000", outValid, outData); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) clk_step(1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0);
        clk_step(1'b0, 16'h0, 1'b1, 1'b0);
        total++; if (got_q.size() !== 1 || exp_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
            bad++; $display("FAIL rst_pre_pop got=%0d words want=1 word 0a01", got_q.size());
        end
        got_q.delete(); exp_q.delete();
        outReady = 1'b1;
        #2 rstN = 1'b0;
        #1;
        total++; if (outValid !== 1'b0 || outData !== 16'h0 || level !== 4'd0 || empty !== 1'b1 ||
                     full !== 1'b0 || almostFull !== 1'b0 || overflow !== 1'b0 || dropCount !== 8'd0) begin
            bad++; $display("FAIL rst_async got v=%b d=%h l=%0d e=%b f=%b af=%b o=%b dc=%0d want reset values",
                            outValid, outData, level, empty, full, almostFull, overflow, dropCount);
        end
        sb.delete();
        @(posedge clk);
        #1 rstN = 1'b1;
        clk_step(1'b0, 16'h0, 1'b1, 1'b0);
        total++; if (level !== 4'd0 || outValid !== 1'b0) begin bad++; $display("FAIL rst_after got=%0d/%b want=0/0", level, outValid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
